// File: rtl/fft_pkg.sv
// Shared constants and helpers for the SDF FFT datapath blocks.
package fft_pkg;

  localparam int DW_DEFAULT = 24;
  localparam int DEPTH_MAX  = 256;

  // Drain controller states: IDLE (no burst seen since the last flush),
  // FEED (last shift carried a sample), RUN (zero-insert drain counting down).
  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_FEED = 2'd1,
    DRAIN_RUN  = 2'd2
  } drain_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_drain_ctrl.sv
// Shift-enable and drain generation for the SDF delay line: after a burst
// ends it keeps the line shifting for exactly DEPTH zero-insert cycles.
module sdf_drain_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       en,
  output logic       draining,
  output logic [1:0] state_dbg
);

  localparam int CW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [CW-1:0] LOAD = CW'(DEPTH - 1);

  drain_state_e  state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= DRAIN_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt holds the zero-insert shifts still owed after the current one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    draining = 1'b0;
    case (state)
      DRAIN_IDLE: begin
        if (in_valid) state_nx = DRAIN_FEED;
      end
      DRAIN_FEED: begin
        if (!in_valid) begin
          draining = 1'b1;
          if (DEPTH == 1) begin
            state_nx = DRAIN_IDLE;
          end else begin
            state_nx = DRAIN_RUN;
            cnt_nx   = LOAD;
          end
        end
      end
      DRAIN_RUN: begin
        draining = 1'b1;
        if (in_valid) begin
          state_nx = DRAIN_FEED;
        end else if (cnt == CW'(1)) begin
          state_nx = DRAIN_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = DRAIN_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign en        = in_valid | draining;
  assign state_dbg = state;

endmodule

// File: rtl/sdf_delay_line.sv
// DEPTH-sample complex delay line for a single-path delay-feedback FFT stage,
// with per-entry valid tags, automatic drain and butterfly phase output.
module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i,
  output logic          out_valid,
  output logic          phase,
  output logic          busy
);

  localparam int PW = clog2(2 * DEPTH);

  // Handshake: in_valid is a valid-only qualifier with no back-pressure; a
  // sample is taken on every rising edge where in_valid=1 and rst/clr are low,
  // and out_valid marks the cycles in which dout_r/dout_i hold a real sample.

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DW-1:0]    mem_i [DEPTH];
  logic [DEPTH-1:0] tag;
  logic [PW-1:0]    ph_cnt;
  logic             en;
  logic             draining;
  logic [1:0]       drain_state;

  sdf_drain_ctrl #(
    .DEPTH (DEPTH)
  ) u_drain_ctrl (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .en        (en),
    .draining  (draining),
    .state_dbg (drain_state)
  );

  // Register chain rather than RAM so every entry clears on rst/clr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
      tag    <= '0;
      ph_cnt <= '0;
    end else if (en) begin
      mem_r[0] <= in_valid ? din_r : '0;
      mem_i[0] <= in_valid ? din_i : '0;
      tag[0]   <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        mem_r[k] <= mem_r[k-1];
        mem_i[k] <= mem_i[k-1];
        tag[k]   <= tag[k-1];
      end
      ph_cnt <= ph_cnt + 1'b1;
    end
  end

  assign dout_r    = mem_r[DEPTH-1];
  assign dout_i    = mem_i[DEPTH-1];
  assign out_valid = tag[DEPTH-1];
  assign phase     = ph_cnt[PW-1];
  assign busy      = draining | (|tag);

  // A live drain or feed state always implies a sample still in the line.
  a_state_implies_busy : assert property (
    @(posedge clk) disable iff (rst)
    (drain_state != 2'(DRAIN_IDLE)) |-> busy
  );

endmodule

// File: tb/tb_sdf_delay_line.sv
// Bench for sdf_delay_line: DEPTH=8 and DEPTH=1 instances share the stimulus
// and are checked every cycle against a queue-style model plus literal pins.
module tb_sdf_delay_line;

  localparam int DW = 24;
  localparam logic [DW-1:0] JUNK = 24'h5A5A5A;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din_r = '0;
  logic [DW-1:0] din_i = '0;

  logic [DW-1:0] o8_r, o8_i, o1_r, o1_i;
  logic          ov8, ph8, bz8, ov1, ph1, bz1;

  sdf_delay_line #(.DW(DW), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .dout_r(o8_r), .dout_i(o8_i),
    .out_valid(ov8), .phase(ph8), .busy(bz8)
  );

  sdf_delay_line #(.DW(DW), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
    .din_r(din_r), .din_i(din_i), .dout_r(o1_r), .dout_i(o1_i),
    .out_valid(ov1), .phase(ph1), .busy(bz1)
  );

  logic [DW-1:0] g_r [2];
  logic [DW-1:0] g_i [2];
  logic          g_v [2];
  logic          g_p [2];
  logic          g_b [2];
  assign g_r[0] = o8_r;  assign g_r[1] = o1_r;
  assign g_i[0] = o8_i;  assign g_i[1] = o1_i;
  assign g_v[0] = ov8;   assign g_v[1] = ov1;
  assign g_p[0] = ph8;   assign g_p[1] = ph1;
  assign g_b[0] = bz8;   assign g_b[1] = bz1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int unit, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, unit, $time, got, exp);
    end
  endtask

  // Model: each line is an array of slots; any accepted sample owes DEPTH
  // further shifts, each invalid cycle pays one of them with a zero slot.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] r;
    logic [DW-1:0] i;
  } ent_t;

  ent_t m_ln [2][8];
  int   m_dep [2] = '{8, 1};
  int   m_ph [2];
  int   m_owed [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst || clr) begin
        for (int k = 0; k < 8; k++) m_ln[u][k] = '0;
        m_ph[u]   = 0;
        m_owed[u] = 0;
      end else if (in_valid || m_owed[u] > 0) begin
        for (int k = m_dep[u] - 1; k > 0; k--) m_ln[u][k] = m_ln[u][k-1];
        m_ln[u][0] = in_valid ? {1'b1, din_r, din_i} : '0;
        m_ph[u]    = (m_ph[u] + 1) % (2 * m_dep[u]);
        m_owed[u]  = in_valid ? m_dep[u] : m_owed[u] - 1;
      end
    end
  end

  function automatic logic m_busy(input int u);
    for (int k = 0; k < m_dep[u]; k++) if (m_ln[u][k].v) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        chk("cmp_dout_r", u, 32'(g_r[u]), 32'(m_ln[u][m_dep[u]-1].r));
        chk("cmp_dout_i", u, 32'(g_i[u]), 32'(m_ln[u][m_dep[u]-1].i));
        chk("cmp_valid",  u, 32'(g_v[u]), 32'(m_ln[u][m_dep[u]-1].v));
        chk("cmp_phase",  u, 32'(g_p[u]), 32'(m_ph[u] >= m_dep[u]));
        chk("cmp_busy",   u, 32'(g_b[u]), 32'(m_busy(u)));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input logic iv, input logic [DW-1:0] r, input logic c,
                      input logic rs);
    @(posedge clk);
    #1;
    rst      = rs;
    clr      = c;
    in_valid = iv;
    din_r    = r;
    din_i    = -r;
    @(negedge clk);
  endtask

  logic [7:0] pat;

  initial begin
    // reset
    tick(1'b0, JUNK, 1'b0, 1'b1);
    chk_en = 1'b1;
    tick(1'b1, JUNK, 1'b0, 1'b1);
    chk("rst_dout_r", 0, 32'(o8_r), 32'h0);
    chk("rst_valid",  0, 32'(ov8), 32'h0);
    chk("rst_phase",  0, 32'(ph8), 32'h0);
    chk("rst_busy",   0, 32'(bz8), 32'h0);

    // continuous ramp 1..16, then idle
    for (int c = 0; c < 16; c++) begin
      tick(1'b1, DW'(c + 1), 1'b0, 1'b0);
      if (c == 7) begin
        chk("ramp_c7_valid", 0, 32'(ov8), 32'h0);
        chk("ramp_c7_phase", 0, 32'(ph8), 32'h0);
      end
      if (c == 8) begin
        chk("ramp_c8_r",     0, 32'(o8_r), 32'h1);
        chk("ramp_c8_i",     0, 32'(o8_i), 32'hFFFFFF);
        chk("ramp_c8_valid", 0, 32'(ov8), 32'h1);
        chk("ramp_c8_phase", 0, 32'(ph8), 32'h1);
        chk("model_pin_c8",  0, 32'(m_ln[0][7].r), 32'h1);
      end
      if (c == 15) chk("ramp_c15_r", 0, 32'(o8_r), 32'h8);
    end
    for (int c = 16; c < 26; c++) begin
      tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c == 16) begin
        chk("ramp_c16_r",     0, 32'(o8_r), 32'h9);
        chk("ramp_c16_phase", 0, 32'(ph8), 32'h0);
      end
      if (c == 24) chk("ramp_c24_busy", 0, 32'(bz8), 32'h0);
    end

    // burst 1..5 then drain
    tick(1'b0, JUNK, 1'b0, 1'b1);
    for (int c = 0; c < 17; c++) begin
      if (c < 5) tick(1'b1, DW'(c + 1), 1'b0, 1'b0);
      else       tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c == 8)  chk("burst_c8_r", 0, 32'(o8_r), 32'h1);
      if (c == 12) begin
        chk("burst_c12_r",     0, 32'(o8_r), 32'h5);
        chk("burst_c12_valid", 0, 32'(ov8), 32'h1);
        chk("burst_c12_busy",  0, 32'(bz8), 32'h1);
      end
      if (c == 13) begin
        chk("burst_c13_r",     0, 32'(o8_r), 32'h0);
        chk("burst_c13_valid", 0, 32'(ov8), 32'h0);
        chk("burst_c13_busy",  0, 32'(bz8), 32'h0);
      end
      if (c == 15) chk("burst_c15_phase_held", 0, 32'(ph8), 32'h1);
    end

    // burst 3, gap 2, burst 3
    tick(1'b0, JUNK, 1'b0, 1'b1);
    pat = 8'b1110_0111;
    for (int c = 0; c < 21; c++) begin
      if (c < 3)      tick(1'b1, DW'(10 + c), 1'b0, 1'b0);
      else if (c < 5) tick(1'b0, JUNK, 1'b0, 1'b0);
      else if (c < 8) tick(1'b1, DW'(15 + c), 1'b0, 1'b0);
      else            tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c >= 8 && c < 16) chk("gap_valid_pat", 0, 32'(ov8), 32'(pat[15 - c]));
      if (c == 13) chk("gap_c13_r", 0, 32'(o8_r), 32'd20);
    end

    // clr in cycle 4 of a continuous burst
    tick(1'b0, JUNK, 1'b0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      if (c < 14) tick(1'b1, DW'(c + 1), (c == 4), 1'b0);
      else        tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c == 5) begin
        chk("clr_c5_phase", 0, 32'(ph8), 32'h0);
        chk("clr_c5_valid", 0, 32'(ov8), 32'h0);
      end
      if (c == 9)  chk("clr_c9_valid", 0, 32'(ov8), 32'h0);
      if (c == 12) chk("clr_c12_valid", 0, 32'(ov8), 32'h0);
      if (c == 13) begin
        chk("clr_c13_valid", 0, 32'(ov8), 32'h1);
        chk("clr_c13_r",     0, 32'(o8_r), 32'h6);
        chk("clr_c13_phase", 0, 32'(ph8), 32'h1);
      end
    end

    // rst mid-drain
    tick(1'b0, JUNK, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c < 4)       tick(1'b1, DW'(31 + c), 1'b0, 1'b0);
      else if (c == 6) tick(1'b0, JUNK, 1'b0, 1'b1);
      else             tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c == 7) begin
        chk("rstd_c7_r",     0, 32'(o8_r), 32'h0);
        chk("rstd_c7_valid", 0, 32'(ov8), 32'h0);
        chk("rstd_c7_busy",  0, 32'(bz8), 32'h0);
        chk("rstd_c7_phase", 0, 32'(ph8), 32'h0);
      end
      if (c == 11) chk("rstd_c11_phase", 0, 32'(ph8), 32'h0);
    end

    // alternating in_valid, focus on the DEPTH=1 instance
    tick(1'b0, JUNK, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (c < 9 && (c % 2 == 0)) tick(1'b1, DW'(24'h100 + c), 1'b0, 1'b0);
      else                        tick(1'b0, JUNK, 1'b0, 1'b0);
      if (c < 10) chk("d1_phase", 1, 32'(ph1), 32'(c % 2));
      if (c % 2 == 1 && c < 10) begin
        chk("d1_odd_r",     1, 32'(o1_r), 32'(24'h100 + c - 1));
        chk("d1_odd_valid", 1, 32'(ov1), 32'h1);
      end
      if (c % 2 == 0 && c >= 2) chk("d1_even_valid", 1, 32'(ov1), 32'h0);
      if (c == 10) chk("d1_c10_busy", 1, 32'(bz1), 32'h0);
      if (c == 11) chk("d1_c11_phase_hold", 1, 32'(ph1), 32'h0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1);
  end

endmodule
